// File: rtl/mips_step_ctrl_if.sv
// mips_step_ctrl_if
// Bundles the board-side debug controls and the processor-facing outputs of
// the step controller.
//   clk_toggle  raw mode switch (1 = single-step, 0 = free run)
//   clk_button  raw, bouncy step pushbutton
//   bp_en       breakpoint enable
//   bp_addr     breakpoint PC value
//   pc_out      current PC reported by the processor
//   cpu_en      processor clock-enable, one instruction per high cycle
//   halted      high while stopped at a breakpoint
//   step_count  number of cpu_en pulses issued, wraps at 16 bits
//   state_o     controller state: RUN=0, STEP_IDLE=1, STEP_FIRE=2, HALT=3
// master = board/processor side, slave = the controller.
interface mips_step_ctrl_if;
    logic        clk_toggle;
    logic        clk_button;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc_out;
    logic        cpu_en;
    logic        halted;
    logic [15:0] step_count;
    logic [1:0]  state_o;

    modport master (
        output clk_toggle, clk_button, bp_en, bp_addr, pc_out,
        input  cpu_en, halted, step_count, state_o
    );

    modport slave (
        input  clk_toggle, clk_button, bp_en, bp_addr, pc_out,
        output cpu_en, halted, step_count, state_o
    );
endinterface

// File: rtl/mips_step_ctrl.sv
// mips_step_ctrl
// Generates the MIPS core clock-enable from the board debug controls: free
// run with an optional divider, or one instruction per debounced button
// press, with a PC breakpoint that halts free-running execution.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    mips_step_ctrl_if.slave (switch, button, breakpoint, PC in;
//          cpu_en, halted, step_count, state_o out)
//
// state      | meaning
// -----------+--------------------------------------------------------
// RUN        | free run, cpu_en once every RUN_DIV cycles
// STEP_IDLE  | single-step mode, waiting for a button press
// STEP_FIRE  | one-cycle cpu_en pulse for a single step
// HALT       | stopped at breakpoint, waiting for a button press
module mips_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 1
) (
    input logic             clk,
    input logic             reset,
    mips_step_ctrl_if.slave bus
);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_STEP_IDLE = 2'd1;
    localparam logic [1:0] ST_STEP_FIRE = 2'd2;
    localparam logic [1:0] ST_HALT      = 2'd3;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic             tog_m, tog_s;
    logic             btn_m, btn_s;
    logic             deb, deb_d;
    logic [CNT_W-1:0] cnt;
    logic             step_req;

    logic [1:0]       state, state_nx;
    logic [DIV_W-1:0] div, div_nx;
    logic             bp_skip, skip_nx;
    logic             div_fire;
    logic             bp_hit;
    logic             cpu_en_c;
    logic [15:0]      step_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tog_m <= 1'b0;
            tog_s <= 1'b0;
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            tog_m <= bus.clk_toggle;
            tog_s <= tog_m;
            btn_m <= bus.clk_button;
            btn_s <= btn_m;
        end
    end

    // The level is only accepted after it differs from deb for
    // DEBOUNCE_CYCLES consecutive cycles; any return to deb restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb   <= 1'b0;
            deb_d <= 1'b0;
            cnt   <= '0;
        end else begin
            deb_d <= deb;
            if (btn_s == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= btn_s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign step_req = deb & ~deb_d;

    assign div_fire = (div == DIV_LAST);
    // bp_skip lets the breakpoint instruction execute once after a resume.
    assign bp_hit   = bus.bp_en & (bus.pc_out == bus.bp_addr) & ~bp_skip;

    always_comb begin
        state_nx = state;
        div_nx   = div;
        skip_nx  = bp_skip;
        cpu_en_c = 1'b0;
        case (state)
            ST_RUN: begin
                cpu_en_c = div_fire & ~bp_hit;
                div_nx   = div_fire ? '0 : div + 1'b1;
                if (cpu_en_c) begin
                    skip_nx = 1'b0;
                end
                if (div_fire && bp_hit) begin
                    state_nx = ST_HALT;
                end else if (tog_s) begin
                    state_nx = ST_STEP_IDLE;
                end
            end
            ST_STEP_IDLE: begin
                if (step_req) begin
                    state_nx = ST_STEP_FIRE;
                end else if (!tog_s) begin
                    state_nx = ST_RUN;
                    div_nx   = '0;
                end
            end
            ST_STEP_FIRE: begin
                cpu_en_c = 1'b1;
                if (!tog_s) begin
                    state_nx = ST_RUN;
                    div_nx   = '0;
                end else begin
                    state_nx = ST_STEP_IDLE;
                end
            end
            ST_HALT: begin
                if (step_req) begin
                    skip_nx  = 1'b1;
                    state_nx = ST_STEP_FIRE;
                end
            end
            default: state_nx = ST_STEP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_STEP_IDLE;
            div        <= '0;
            bp_skip    <= 1'b0;
            step_count <= '0;
        end else begin
            state   <= state_nx;
            div     <= div_nx;
            bp_skip <= skip_nx;
            if (cpu_en_c) begin
                step_count <= step_count + 16'd1;
            end
        end
    end

    assign bus.cpu_en     = cpu_en_c;
    assign bus.halted     = (state == ST_HALT);
    assign bus.step_count = step_count;
    assign bus.state_o    = state;

endmodule

// File: tb/tb_mips_step_ctrl.sv
// tb_mips_step_ctrl
// Two controllers share the board controls: dut1 with RUN_DIV=1 and dut3
// with RUN_DIV=3, both with a 4-cycle debounce. Each has its own PC model
// that advances by 4 per cpu_en. Expected step-pulse cycles are queued when
// a press is driven and consumed when dut1 issues a step pulse.
module tb_mips_step_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tog = 1'b1;
    logic        btn = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'h10;
    logic [31:0] pc1, pc3;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_q[$];
    bit mon_all = 1'b0;

    mips_step_ctrl_if if1 ();
    mips_step_ctrl_if if3 ();

    assign if1.clk_toggle = tog;
    assign if1.clk_button = btn;
    assign if1.bp_en      = bp_en;
    assign if1.bp_addr    = bp_addr;
    assign if1.pc_out     = pc1;
    assign if3.clk_toggle = tog;
    assign if3.clk_button = btn;
    assign if3.bp_en      = bp_en;
    assign if3.bp_addr    = bp_addr;
    assign if3.pc_out     = pc3;

    mips_step_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    mips_step_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) pc1 <= '0;
        else if (if1.cpu_en) pc1 <= pc1 + 32'd4;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) pc3 <= '0;
        else if (if3.cpu_en) pc3 <= pc3 + 32'd4;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step pulses of dut1 are matched against the queued expected cycles;
    // a pulse with nothing queued compares against -1 and so reports.
    always @(negedge clk) begin
        if (reset && if1.cpu_en && (mon_all || if1.state_o == 2'd2)) begin
            int e;
            e = (exp_q.size() == 0) ? -1 : exp_q.pop_front();
            check("pulse_cyc", 32'(cyc), 32'(e));
        end
    end

    initial begin
        int sc0, sc3, k;

        // T1 reset / idle
        reset = 1'b0;
        tog   = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_rst_state", 32'(if1.state_o), 32'd1);
        check("t1_rst_en", 32'(if1.cpu_en), 32'd0);
        reset = 1'b1;
        #1;
        check("t1_state", 32'(if1.state_o), 32'd1);
        check("t1_state3", 32'(if3.state_o), 32'd1);
        check("t1_cpu_en", 32'(if1.cpu_en), 32'd0);
        check("t1_count", 32'(if1.step_count), 32'd0);
        check("t1_halted", 32'(if1.halted), 32'd0);
        // synchronisers start at run-mode level, so let the mode settle
        repeat (8) @(negedge clk);
        check("t1_settled", 32'(if1.state_o), 32'd1);
        check("t1_settled_en", 32'(if1.cpu_en), 32'd0);

        // T2 clean press
        sc0 = 32'(if1.step_count);
        mon_all = 1'b1;
        btn = 1'b1;
        exp_q.push_back(cyc + 7);
        repeat (20) @(negedge clk);
        check("t2_sb_drain", 32'(exp_q.size()), 32'd0);
        check("t2_count", 32'(if1.step_count), 32'(sc0 + 1));
        check("t2_state", 32'(if1.state_o), 32'd1);
        btn = 1'b0;
        repeat (20) @(negedge clk);
        check("t2_release", 32'(if1.step_count), 32'(sc0 + 1));

        // T3 bounce rejection
        for (int i = 0; i < 30; i++) begin
            btn = ((i % 4) < 2);
            @(negedge clk);
        end
        btn = 1'b0;
        repeat (20) @(negedge clk);
        check("t3_count", 32'(if1.step_count), 32'(sc0 + 1));
        check("t3_state", 32'(if1.state_o), 32'd1);
        mon_all = 1'b0;

        // T4 run divider on dut3
        tog = 1'b0;
        k = 0;
        while (if3.state_o != 2'd0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("t4_run", 32'(if3.state_o), 32'd0);
        sc3 = 32'(if3.step_count);
        for (int i = 0; i < 30; i++) begin
            check("t4_en", 32'(if3.cpu_en), 32'((i % 3) == 2));
            @(negedge clk);
        end
        check("t4_count", 32'(if3.step_count), 32'(sc3 + 10));

        // T5 breakpoint halt and resume
        reset   = 1'b0;
        bp_en   = 1'b1;
        bp_addr = 32'h10;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        k = 0;
        while (!if1.halted && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t5_halted", 32'(if1.halted), 32'd1);
        check("t5_pc", pc1, 32'h10);
        check("t5_cpu_en", 32'(if1.cpu_en), 32'd0);
        check("t5_count", 32'(if1.step_count), 32'd4);
        check("t5_state", 32'(if1.state_o), 32'd3);
        tog = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_tog_hold", 32'(if1.state_o), 32'd3);
        tog = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_still_halt", 32'(if1.halted), 32'd1);
        btn = 1'b1;
        exp_q.push_back(cyc + 7);
        repeat (7) @(negedge clk);
        check("t5_fire_en", 32'(if1.cpu_en), 32'd1);
        check("t5_fire_pc", pc1, 32'h10);
        check("t5_fire_state", 32'(if1.state_o), 32'd2);
        @(negedge clk);
        check("t5_resume_pc", pc1, 32'h14);
        check("t5_resume_state", 32'(if1.state_o), 32'd0);
        btn = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_no_rehalt", 32'(if1.halted), 32'd0);
        check("t5_running", 32'(if1.state_o), 32'd0);
        check("t5_sb_drain", 32'(exp_q.size()), 32'd0);

        // T6 counter wrap and async reset mid-pulse
        bp_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        k = 0;
        while (if1.step_count != 16'hFFFF && k < 70000) begin
            @(negedge clk);
            k++;
        end
        check("t6_preload", 32'(if1.step_count), 32'hFFFF);
        @(negedge clk);
        check("t6_wrap", 32'(if1.step_count), 32'h0);
        @(posedge clk);
        #2;
        check("t6_pre_en", 32'(if1.cpu_en), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_abort_en", 32'(if1.cpu_en), 32'd0);
        check("t6_abort_state", 32'(if1.state_o), 32'd1);
        check("t6_abort_count", 32'(if1.step_count), 32'd0);
        check("t6_abort_halted", 32'(if1.halted), 32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_step_ctrl.md
Name: mips_step_ctrl

Overview:
- Drives the MIPS core's clock-enable from the board-side debug controls.
- The `clk_toggle` switch selects run or single-step mode. Each debounced `clk_button` press issues one `cpu_en` pulse in step mode.
- A PC breakpoint halts free-running execution.
- Sits between the board switch/button pins and `uut_mips_processor`. It is the input end of the processor's `clk_toggle`/`clk_button` interface.

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before the button level is accepted (5 ms at 100 MHz). Minimum 2.
- `RUN_DIV`, default 1: in run mode, `cpu_en` asserts once every `RUN_DIV` cycles. Minimum 1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `clk_toggle`  in  1  raw mode switch, asynchronous; 1 = step mode, 0 = run mode.
- `clk_button`  in  1  raw step pushbutton, asynchronous, bouncy.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  32  breakpoint PC value.
- `pc_out`  in  32  current PC from the processor.
- `cpu_en`  out  1  processor clock-enable; the processor advances one instruction per high cycle.
- `halted`  out  1  high while in HALT.
- `step_count`  out  16  count of `cpu_en` pulses issued, wraps modulo 2^16.
- `state_o`  out  2  FSM state: RUN=0, STEP_IDLE=1, STEP_FIRE=2, HALT=3.

Behaviour:
- **Reset** (`reset`=0, async): state=STEP_IDLE, `cpu_en`=0, `halted`=0, `step_count`=0. Synchronisers, debounced level, debounce counter, divider and `bp_skip` all clear to 0. Asserting reset mid-pulse aborts the pulse immediately.
- **Synchronisers**: `clk_toggle` and `clk_button` each pass through a 2-flop synchroniser, producing `tog_s` and `btn_s`. Only the button is debounced.
- **Debounce**:
  - While `btn_s` != `deb`, `cnt` increments each cycle.
  - When `cnt`==`DEBOUNCE_CYCLES`-1 and `btn_s` != `deb`: `deb`<=`btn_s` and `cnt`<=0.
  - Any cycle with `btn_s`==`deb` sets `cnt`<=0.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles is rejected.
- **Step request**: `step_req` = `deb` & ~`deb_d`, one cycle per press. Releases produce nothing.
- **Press latency**: `cpu_en` goes high exactly `DEBOUNCE_CYCLES`+3 cycles after a clean raw rising edge of `clk_button`.
- **`cpu_en`** is derived combinationally from state and registered signals only:
  - RUN: `cpu_en` = (`div`==`RUN_DIV`-1) & ~`bp_hit`.
  - STEP_FIRE: `cpu_en` = 1.
  - STEP_IDLE and HALT: `cpu_en` = 0.
- **Breakpoint hit**: `bp_hit` = `bp_en` & (`pc_out`==`bp_addr`) & ~`bp_skip`. Checked only in RUN, and only on fire cycles.
- **FSM transitions**:
  - STEP_IDLE: on `step_req` -> STEP_FIRE. Step has priority over a mode change. Otherwise, `tog_s`=0 -> RUN with `div`<=0.
  - STEP_FIRE: lasts exactly one cycle. Next state is RUN (`div`<=0) if `tog_s`=0, else STEP_IDLE. Breakpoints are ignored in step mode.
  - RUN:
    - `div` counts 0..`RUN_DIV`-1 and wraps.
    - On a fire cycle with `bp_hit`: `cpu_en`=0, next state HALT.
    - Otherwise, `tog_s`=1 -> STEP_IDLE. A fire pulse coincident with the switch is still issued.
    - `step_req` is ignored.
  - HALT: `halted`=1, `cpu_en`=0. On `step_req`: `bp_skip`<=1 and next state STEP_FIRE. The exit target then follows `tog_s`. `bp_en`/`tog_s` changes alone do not leave HALT.
- **`bp_skip`**: set on HALT exit. Cleared on the first `cpu_en` pulse issued in RUN, so the instruction at the breakpoint executes once after resume.
- **`step_count`**: increments on every cycle with `cpu_en`=1; 0xFFFF wraps to 0x0000.

Test Plan:
- **T1 reset/idle**: hold `reset`=0 for 3 cycles, then release with `clk_toggle`=1. Expect `state_o`=1, `cpu_en`=0, `step_count`=0, `halted`=0.
- **T2 step press**: `DEBOUNCE_CYCLES`=4, `clk_toggle`=1; raise `clk_button` cleanly and hold 20 cycles. Expect exactly one `cpu_en` pulse, 7 cycles after the edge, and `step_count`=1. Releasing the button gives no pulse.
- **T3 bounce rejection**: `clk_button` toggles with high pulses of 2 cycles for 30 cycles, then settles low. Expect no `cpu_en` and `step_count` unchanged.
- **T4 run divider**: `RUN_DIV`=3, `clk_toggle`=0 from STEP_IDLE. Expect RUN next cycle and `cpu_en` high on every 3rd cycle. After 30 cycles `step_count`=10.
- **T5 breakpoint**:
  - Setup: run mode, `RUN_DIV`=1, `bp_en`=1, `bp_addr`=0x00000010. Model `pc_out` += 4 per `cpu_en`, starting at 0.
  - Expect HALT with `pc_out`=0x10, `halted`=1, `cpu_en`=0, `step_count`=4.
  - Then press the button: expect one pulse with `pc_out`->0x14, return to RUN, and no re-halt at 0x10.
- **T6 reset mid-run / counter wrap**: preload by running until `step_count`=0xFFFF. One more pulse gives 0x0000. Assert `reset` asynchronously between clock edges: `cpu_en` drops at once and the state goes to STEP_IDLE.
